// File: rtl/press_pulse_gen.sv
// Two-player press front end: sync, debounce and one-shot move pulses.
// Optional CPU-driven player 2 enabled by defining PRESS_PULSE_CPU_P2_EN.
module press_pulse_gen #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int CNT_W           = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       key_p1_n,
    input  logic       key_p2_n,
`ifdef PRESS_PULSE_CPU_P2_EN
    input  logic       cpu_mode,
    input  logic [9:0] cpu_level,
`endif
    input  logic       freeze,
    output logic       p1in,
    output logic       p2in,
    output logic       tie
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [1:0]       s1_q, s1_d;
    logic [1:0]       s2_q, s2_d;
    logic [1:0]       deb_q, deb_d;
    logic [CNT_W-1:0] cnt_q [2];
    logic [CNT_W-1:0] cnt_d [2];
    logic [1:0]       q;
    logic             p1_q, p1_d;
    logic             p2_q, p2_d;
    logic             tie_q, tie_d;

`ifdef PRESS_PULSE_CPU_P2_EN
    logic [9:0] lfsr_q, lfsr_d;

    // x^10 + x^7 + 1, shifting left; the seed keeps it off the all-zero state
    always_comb begin
        lfsr_d = {lfsr_q[8:0], lfsr_q[9] ^ lfsr_q[6]};
    end

    always_ff @(posedge clk) begin
        if (reset) lfsr_q <= 10'h001;
        else       lfsr_q <= lfsr_d;
    end
`endif

    always_comb begin
        s1_d  = {key_p2_n, key_p1_n};
        s2_d  = s1_q;
        deb_d = deb_q;
        q     = 2'b00;
        for (int i = 0; i < 2; i++) begin
            cnt_d[i] = cnt_q[i];
            if (s2_q[i] == deb_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] == CNT_MAX) begin
                deb_d[i] = s2_q[i];
                cnt_d[i] = '0;
                // only the falling edge of the debounced level is a press
                q[i]     = ~s2_q[i];
            end else begin
                cnt_d[i] = cnt_q[i] + 1'b1;
            end
        end
`ifdef PRESS_PULSE_CPU_P2_EN
        if (cpu_mode) begin
            s1_d[1]  = 1'b1;
            s2_d[1]  = 1'b1;
            deb_d[1] = 1'b1;
            cnt_d[1] = '0;
            q[1]     = (lfsr_q < cpu_level) && !p2_q;
        end
`endif
        p1_d  = q[0] & ~q[1] & ~freeze;
        p2_d  = q[1] & ~q[0] & ~freeze;
        tie_d = q[0] &  q[1] & ~freeze;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_q     <= 2'b11;
            s2_q     <= 2'b11;
            deb_q    <= 2'b11;
            cnt_q[0] <= '0;
            cnt_q[1] <= '0;
            p1_q     <= 1'b0;
            p2_q     <= 1'b0;
            tie_q    <= 1'b0;
        end else begin
            s1_q     <= s1_d;
            s2_q     <= s2_d;
            deb_q    <= deb_d;
            cnt_q[0] <= cnt_d[0];
            cnt_q[1] <= cnt_d[1];
            p1_q     <= p1_d;
            p2_q     <= p2_d;
            tie_q    <= tie_d;
        end
    end

    assign p1in = p1_q;
    assign p2in = p2_q;
    assign tie  = tie_q;

endmodule

// File: tb/tb_press_pulse_gen.sv
// Directed vector bench for press_pulse_gen (DEBOUNCE_CYCLES = 4).
module tb_press_pulse_gen;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic key_p1_n = 1'b1;
    logic key_p2_n = 1'b1;
    logic freeze = 1'b0;
    logic p1in, p2in, tie;
`ifdef PRESS_PULSE_CPU_P2_EN
    logic       cpu_mode = 1'b0;
    logic [9:0] cpu_level = 10'h000;
`endif

    int n_chk = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    press_pulse_gen #(.DEBOUNCE_CYCLES(4), .CNT_W(8)) dut (
        .clk      (clk),
        .reset    (reset),
        .key_p1_n (key_p1_n),
        .key_p2_n (key_p2_n),
`ifdef PRESS_PULSE_CPU_P2_EN
        .cpu_mode (cpu_mode),
        .cpu_level(cpu_level),
`endif
        .freeze   (freeze),
        .p1in     (p1in),
        .p2in     (p2in),
        .tie      (tie)
    );

    typedef struct {
        bit rst, k1, k2, fz;
        bit e1, e2, et;
    } vec_t;

    vec_t tbl[$];

    task automatic v(input int n, input bit r, input bit k1, input bit k2,
                     input bit fz, input bit e1, input bit e2, input bit et);
        vec_t x;
        x.rst = r; x.k1 = k1; x.k2 = k2; x.fz = fz;
        x.e1 = e1; x.e2 = e2; x.et = et;
        for (int i = 0; i < n; i++) tbl.push_back(x);
    endtask

    task automatic chk(input string nm, input logic [2:0] act,
                       input logic [2:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got {p1,p2,tie}=%b expected %b",
                      nm, act, exp);
    endtask

    // p1in and p2in must never be high together
    always @(negedge clk) begin
        if (!reset) chk("excl", {p1in & p2in, 2'b00}, 3'b000);
    end

    initial begin
        int n;
        int cnt;
        bit prev;

        // reset and idle
        v(2, 1, 1, 1, 0, 0, 0, 0);
        v(12, 0, 1, 1, 0, 0, 0, 0);
        // p1 press held 20 cycles, then release
        v(5, 0, 0, 1, 0, 0, 0, 0);
        v(1, 0, 0, 1, 0, 1, 0, 0);
        v(14, 0, 0, 1, 0, 0, 0, 0);
        v(10, 0, 1, 1, 0, 0, 0, 0);
        // p2 bounce then stable low
        for (int i = 0; i < 3; i++) begin
            v(1, 0, 1, 0, 0, 0, 0, 0);
            v(1, 0, 1, 1, 0, 0, 0, 0);
        end
        v(5, 0, 1, 0, 0, 0, 0, 0);
        v(1, 0, 1, 0, 0, 0, 1, 0);
        v(6, 0, 1, 0, 0, 0, 0, 0);
        v(10, 0, 1, 1, 0, 0, 0, 0);
        // simultaneous press
        v(5, 0, 0, 0, 0, 0, 0, 0);
        v(1, 0, 0, 0, 0, 0, 0, 1);
        v(4, 0, 0, 0, 0, 0, 0, 0);
        v(10, 0, 1, 1, 0, 0, 0, 0);
        // freeze, drop freeze mid-hold, release, re-press
        v(8, 0, 0, 1, 1, 0, 0, 0);
        v(8, 0, 0, 1, 0, 0, 0, 0);
        v(10, 0, 1, 1, 0, 0, 0, 0);
        v(5, 0, 0, 1, 0, 0, 0, 0);
        v(1, 0, 0, 1, 0, 1, 0, 0);
        v(2, 0, 0, 1, 0, 0, 0, 0);
        v(10, 0, 1, 1, 0, 0, 0, 0);
        // reset mid-debounce restarts the whole pipeline
        v(3, 0, 0, 1, 0, 0, 0, 0);
        v(1, 1, 0, 1, 0, 0, 0, 0);
        v(5, 0, 0, 1, 0, 0, 0, 0);
        v(1, 0, 0, 1, 0, 1, 0, 0);
        v(3, 0, 0, 1, 0, 0, 0, 0);
        v(10, 0, 1, 1, 0, 0, 0, 0);
        // reset on the pulse edge kills it; held key re-qualifies
        v(5, 0, 1, 0, 0, 0, 0, 0);
        v(1, 1, 1, 0, 0, 0, 0, 0);
        v(5, 0, 1, 0, 0, 0, 0, 0);
        v(1, 0, 1, 0, 0, 0, 1, 0);
        v(2, 0, 1, 0, 0, 0, 0, 0);
        v(10, 0, 1, 1, 0, 0, 0, 0);

        foreach (tbl[i]) begin
            @(negedge clk);
            reset = tbl[i].rst;
            key_p1_n = tbl[i].k1;
            key_p2_n = tbl[i].k2;
            freeze = tbl[i].fz;
            @(posedge clk);
            #1;
            chk($sformatf("vec%0d", i), {p1in, p2in, tie},
                {tbl[i].e1, tbl[i].e2, tbl[i].et});
        end

        // p2 press latency measured with a bounded wait
        @(negedge clk);
        key_p2_n = 1'b0;
        n = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            n++;
            if (p2in) break;
        end
        chk("p2_lat", 3'(n), 3'd6);
        cnt = 0;
        for (int i = 0; i < 15; i++) begin
            @(posedge clk);
            #1;
            if (p2in) cnt++;
        end
        chk("p2_hold", 3'(cnt), 3'd0);
        @(negedge clk);
        key_p2_n = 1'b1;
        repeat (10) @(posedge clk);

`ifdef PRESS_PULSE_CPU_P2_EN
        @(negedge clk);
        cpu_mode = 1'b1;
        cpu_level = 10'h3FF;
        key_p2_n = 1'b0;
        cnt = 0;
        prev = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (p2in && prev) chk("cpu_b2b", 3'b100, 3'b000);
            if (p2in) cnt++;
            prev = p2in;
        end
        n_chk++;
        if (cnt >= 90) n_pass++;
        else $display("FAIL cpu_rate: got %0d pulses, required >= 90", cnt);
        cpu_level = 10'h000;
        repeat (3) @(negedge clk);
        cnt = 0;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (p2in) cnt++;
        end
        n_chk++;
        if (cnt == 0) n_pass++;
        else $display("FAIL cpu_zero: got %0d pulses, required 0", cnt);
        cpu_mode = 1'b0;
        key_p2_n = 1'b1;
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/press_pulse_gen.md
Name: press_pulse_gen

Overview:
- Front end that produces the per-player move pulses consumed by the tug-of-war light chain, which advances on single-cycle move requests.
- Takes the two raw, asynchronous, active-low DE1 KEY inputs and synchronizes and debounces each one.
- Emits exactly one single-cycle pulse per physical press on p1in / p2in.
- Suppresses simultaneous presses and all moves after game over.

Parameters:
- DEBOUNCE_CYCLES, default 4: consecutive cycles a synchronized level must differ from the debounced level before it is accepted; legal range 1..255.
- CNT_W, default 8: width of each debounce counter; must hold DEBOUNCE_CYCLES.

Ports:
- clk  in  1  system clock
- reset  in  1  reset, synchronous, active-high
- key_p1_n  in  1  raw player-1 button, asynchronous, 0 = pressed
- key_p2_n  in  1  raw player-2 button, asynchronous, 0 = pressed
- freeze  in  1  game over; 1 blocks all pulses
- p1in  out  1  player-1 move pulse, one cycle
- p2in  out  1  player-2 move pulse, one cycle
- tie  out  1  one-cycle flag: both presses qualified on the same edge and were cancelled

Behaviour:
- Reset (reset = 1 at a posedge) sets:
  - sync flops s1, s2 = 1 (released)
  - debounced level deb = 1 (released)
  - counters = 0
  - p1in = p2in = tie = 0
- Reset wins over every other event, including mid-debounce and mid-pulse.
- Per-player synchronizer: two flops, s1 <= key_n, s2 <= s1.
- Per-player debounce, evaluated each edge:
  - If s2 == deb: cnt <= 0.
  - Else if cnt == DEBOUNCE_CYCLES-1: deb <= s2, cnt <= 0.
  - Else: cnt <= cnt+1.
  - Any bounce back to the deb level restarts the count.
- Qualify: q = 1 on the edge where deb transitions 1 -> 0 (press accepted). A release (0 -> 1) never produces a pulse. A held key never repeats.
- Output register, updated on the same edge as q:
  - q1 & ~q2 & ~freeze: p1in <= 1
  - q2 & ~q1 & ~freeze: p2in <= 1
  - q1 & q2 & ~freeze: p1in = p2in = 0, tie <= 1
  - Otherwise all three <= 0
- Latency: if edge k is the first edge at which s1 samples a stable low, the pulse is high from edge k+1+DEBOUNCE_CYCLES to edge k+2+DEBOUNCE_CYCLES. With the default of 4, the pulse rises 5 edges after the first sample.
- Pulse width is exactly one cycle. p1in and p2in are never both high.
- Freeze:
  - Outputs are forced 0 while freeze = 1.
  - Debounce state keeps tracking during freeze.
  - Presses qualified during freeze are discarded, not queued.
  - Deasserting freeze while a key is held produces no pulse; a new press is required.
- Minimum press-to-press spacing: a second pulse needs release plus re-press, each lasting DEBOUNCE_CYCLES.

Optional Feature:
- Macro: PRESS_PULSE_CPU_P2_EN.
- When defined, adds two inputs:
  - cpu_mode, 1 bit
  - cpu_level, 10 bits
- A 10-bit Fibonacci LFSR is added:
  - polynomial x^10+x^7+1
  - reset value 10'h001
  - advances every cycle, never all-zero
- When cpu_mode = 1:
  - key_p2_n is ignored and the p2 debouncer is held at reset values.
  - A CPU request q2 = 1 is generated when lfsr < cpu_level and p2in was 0 in the previous cycle, so no back-to-back pulses.
  - q2 then feeds the same tie and freeze logic.
  - cpu_level = 0 means the CPU never presses.
- When cpu_mode = 0: identical to the macro-undefined behaviour.
- When undefined: no extra ports, no LFSR; p2 comes from the key only.

Test Plan:
- Reset with both keys high, then 10 idle cycles -> p1in = p2in = tie = 0 throughout; deb = 1.
- key_p1_n driven low 2 cycles after reset and held 20 cycles (DEBOUNCE_CYCLES = 4) -> p1in high for exactly one cycle, 5 edges after s1 first samples 0; no further pulse while held; none on release.
- key_p2_n bouncing 0,1,0,1 each cycle for 6 cycles, then stable 0 -> counter restarts on each bounce; exactly one p2in pulse, 5 edges after the stable low begins.
- Both keys driven low on the same cycle and held -> tie high one cycle; p1in = p2in = 0 throughout.
- freeze = 1, press p1 and hold, drop freeze mid-hold, then release and re-press -> no pulse during freeze or at freeze release; exactly one p1in pulse after the re-press.
- PRESS_PULSE_CPU_P2_EN defined, cpu_mode = 1, cpu_level = 10'h3FF, key_p2_n held 0 -> p2in pulses on alternating cycles, never two consecutive; with cpu_level = 0, p2in stays 0 for 2000 cycles.
